marble_dispense_ctrl: RTL and testbench

Top-level sequencer for the marble dispenser servo path. Periodically samples the moisture reading, maps it to a 2-bit marble code, and runs the enable/done handshake with the servo marble dispenser. It pulses the dispenser's reset afterwards, because the dispenser's done flag stays set until that reset. It sits between the moisture-sensor front end and the servo marble dispenser, and also provides a dispense timeout watchdog and status outputs.

---
 rtl/marble_dispense_ctrl_pkg.sv | 25 ++
 rtl/marble_dispense_ctrl_moisture_to_marble.sv | 34 +++
 rtl/marble_dispense_ctrl.sv | 163 ++++++++++++++++
 tb/tb_marble_dispense_ctrl.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/marble_dispense_ctrl_pkg.sv
// Shared definitions for the marble dispenser sequencer.
// Holds the FSM state type, the 2-bit marble codes and the default
// moisture thresholds so other sensor-driven controllers can reuse them.
package marble_dispense_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE        = 3'd0,
        ST_WAIT_SAMPLE = 3'd1,
        ST_DECIDE      = 3'd2,
        ST_DISPENSE    = 3'd3,
        ST_CLEAR       = 3'd4,
        ST_COOLDOWN    = 3'd5,
        ST_FAULT       = 3'd6
    } state_e;

    localparam logic [1:0] MARBLE_NONE = 2'd0;
    localparam logic [1:0] MARBLE_LOW  = 2'd1;
    localparam logic [1:0] MARBLE_MID  = 2'd2;
    localparam logic [1:0] MARBLE_MAX  = 2'd3;

    localparam int unsigned DEFAULT_THRESH_HI  = 3000;
    localparam int unsigned DEFAULT_THRESH_MID = 2000;
    localparam int unsigned DEFAULT_THRESH_LO  = 1000;

endpackage

// File: rtl/marble_dispense_ctrl_moisture_to_marble.sv
// Combinational threshold comparator: maps a moisture reading to a
// 2-bit marble code. Higher reading = drier = larger code; a reading
// exactly on a threshold takes the higher code.
// Ports:
//   moisture - sensor reading (MOIST_W bits)
//   marble   - resulting code, MARBLE_NONE..MARBLE_MAX
module moisture_to_marble
    import marble_dispense_ctrl_pkg::*;
#(
    parameter int unsigned MOIST_W    = 12,
    parameter int unsigned THRESH_HI  = DEFAULT_THRESH_HI,
    parameter int unsigned THRESH_MID = DEFAULT_THRESH_MID,
    parameter int unsigned THRESH_LO  = DEFAULT_THRESH_LO
) (
    input  logic [MOIST_W-1:0] moisture,
    output logic [1:0]         marble
);

    localparam logic [MOIST_W-1:0] TH_HI  = MOIST_W'(THRESH_HI);
    localparam logic [MOIST_W-1:0] TH_MID = MOIST_W'(THRESH_MID);
    localparam logic [MOIST_W-1:0] TH_LO  = MOIST_W'(THRESH_LO);

    always_comb begin
        marble = MARBLE_NONE;
        if (moisture >= TH_HI) begin
            marble = MARBLE_MAX;
        end else if (moisture >= TH_MID) begin
            marble = MARBLE_MID;
        end else if (moisture >= TH_LO) begin
            marble = MARBLE_LOW;
        end
    end

endmodule

// File: rtl/marble_dispense_ctrl.sv
// Sequencer for the servo marble dispenser. Samples moisture, maps it to
// a marble code, runs the enable/done handshake, pulses the dispenser
// reset to clear its sticky done flag, then cools down before the next
// sample. A watchdog faults the path if done never arrives.
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   arm                 - level, run periodic cycles while high
//   clear_fault         - pulse, leaves FAULT
//   moisture(_valid)    - sensor sample and its strobe
//   done_servo_marble   - sticky done from dispenser
//   enable_servo_marble - dispenser enable
//   rst_servo_marble    - dispenser reset
//   marble              - code to dispenser, stable while enabled
//   busy, fault         - status
//   dispense_count      - completed dispenses, saturating at 255
// All outputs come straight from flops.
module marble_dispense_ctrl
    import marble_dispense_ctrl_pkg::*;
#(
    parameter int unsigned MOIST_W    = 12,
    parameter int unsigned THRESH_HI  = DEFAULT_THRESH_HI,
    parameter int unsigned THRESH_MID = DEFAULT_THRESH_MID,
    parameter int unsigned THRESH_LO  = DEFAULT_THRESH_LO,
    parameter int unsigned COOLDOWN   = 100_000_000,
    parameter int unsigned TIMEOUT    = 1_000_000_000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               arm,
    input  logic               clear_fault,
    input  logic [MOIST_W-1:0] moisture,
    input  logic               moisture_valid,
    input  logic               done_servo_marble,
    output logic               enable_servo_marble,
    output logic               rst_servo_marble,
    output logic [1:0]         marble,
    output logic               busy,
    output logic               fault,
    output logic [7:0]         dispense_count
);

    localparam logic [31:0] COOL_LAST    = 32'(COOLDOWN - 1);
    localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT - 1);

    state_e             state_q, state_d;
    logic [31:0]        timer_q, timer_d;
    logic [MOIST_W-1:0] moist_q, moist_d;
    logic [1:0]         marble_q, marble_d;
    logic               enable_q, enable_d;
    logic               rst_servo_q, rst_servo_d;
    logic               busy_q, busy_d;
    logic               fault_q, fault_d;
    logic [7:0]         count_q, count_d;
    logic [1:0]         code;

    moisture_to_marble #(
        .MOIST_W    (MOIST_W),
        .THRESH_HI  (THRESH_HI),
        .THRESH_MID (THRESH_MID),
        .THRESH_LO  (THRESH_LO)
    ) u_m2m (
        .moisture (moist_q),
        .marble   (code)
    );

    always_comb begin
        state_d = state_q;
        moist_d = moist_q;
        unique case (state_q)
            ST_IDLE: begin
                if (arm) state_d = ST_WAIT_SAMPLE;
            end
            ST_WAIT_SAMPLE: begin
                if (!arm) begin
                    state_d = ST_IDLE;
                end else if (moisture_valid) begin
                    moist_d = moisture;
                    state_d = ST_DECIDE;
                end
            end
            ST_DECIDE: begin
                state_d = (code == MARBLE_NONE) ? ST_COOLDOWN : ST_DISPENSE;
            end
            ST_DISPENSE: begin
                if (done_servo_marble) begin
                    state_d = ST_CLEAR;
                end else if (timer_q == TIMEOUT_LAST) begin
                    state_d = ST_FAULT;
                end
            end
            ST_CLEAR: begin
                state_d = ST_COOLDOWN;
            end
            ST_COOLDOWN: begin
                if (timer_q == COOL_LAST) begin
                    state_d = arm ? ST_WAIT_SAMPLE : ST_IDLE;
                end
            end
            ST_FAULT: begin
                if (clear_fault) state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // One shared timer; any state change restarts it from zero.
        timer_d = '0;
        if ((state_d == state_q) &&
            ((state_q == ST_DISPENSE) || (state_q == ST_COOLDOWN))) begin
            timer_d = timer_q + 32'd1;
        end

        // Outputs are computed from the next state so the registered
        // versions line up with state_q.
        marble_d = MARBLE_NONE;
        if (state_d == ST_DISPENSE) begin
            marble_d = (state_q == ST_DISPENSE) ? marble_q : code;
        end

        enable_d    = (state_d == ST_DISPENSE);
        rst_servo_d = (state_d == ST_CLEAR) || (state_d == ST_FAULT);
        busy_d      = (state_d != ST_IDLE);
        fault_d     = (state_d == ST_FAULT);

        count_d = count_q;
        if ((state_d == ST_CLEAR) && (count_q != 8'hFF)) begin
            count_d = count_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            timer_q     <= '0;
            moist_q     <= '0;
            marble_q    <= MARBLE_NONE;
            enable_q    <= 1'b0;
            rst_servo_q <= 1'b1;
            busy_q      <= 1'b0;
            fault_q     <= 1'b0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            moist_q     <= moist_d;
            marble_q    <= marble_d;
            enable_q    <= enable_d;
            rst_servo_q <= rst_servo_d;
            busy_q      <= busy_d;
            fault_q     <= fault_d;
            count_q     <= count_d;
        end
    end

    assign enable_servo_marble = enable_q;
    assign rst_servo_marble    = rst_servo_q;
    assign marble              = marble_q;
    assign busy                = busy_q;
    assign fault               = fault_q;
    assign dispense_count      = count_q;

endmodule

// File: tb/tb_marble_dispense_ctrl.sv
// Directed bench for marble_dispense_ctrl with COOLDOWN=20, TIMEOUT=50.
module tb_marble_dispense_ctrl;

    logic        clk = 1'b0;
    logic        rst, arm, clear_fault, moisture_valid, done_servo_marble;
    logic [11:0] moisture;
    logic        enable_servo_marble, rst_servo_marble, busy, fault;
    logic [1:0]  marble;
    logic [7:0]  dispense_count;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;

    marble_dispense_ctrl #(
        .MOIST_W  (12),
        .COOLDOWN (20),
        .TIMEOUT  (50)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .arm                 (arm),
        .clear_fault         (clear_fault),
        .moisture            (moisture),
        .moisture_valid      (moisture_valid),
        .done_servo_marble   (done_servo_marble),
        .enable_servo_marble (enable_servo_marble),
        .rst_servo_marble    (rst_servo_marble),
        .marble              (marble),
        .busy                (busy),
        .fault               (fault),
        .dispense_count      (dispense_count)
    );

    always #5 clk = ~clk;

    task automatic tick(input int unsigned n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input string tag, input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        sb.push_back(e);
    endtask

    task automatic chk(input logic [31:0] obs);
        exp_t e;
        n_checks++;
        if (sb.size() == 0) begin
            n_errors++;
            $error("FAIL scoreboard_empty observed=%0d expected=none", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.val) else begin
                n_errors++;
                $error("FAIL %s observed=%0d expected=%0d", e.tag, obs, e.val);
            end
        end
    endtask

    initial begin
        bit found;
        rst = 1'b1; arm = 1'b0; clear_fault = 1'b0;
        moisture = '0; moisture_valid = 1'b0; done_servo_marble = 1'b0;

        // Reset state
        push("rst_enable", 0); push("rst_rst_servo", 1); push("rst_marble", 0);
        push("rst_busy", 0); push("rst_fault", 0); push("rst_count", 0);
        tick(2);
        chk(enable_servo_marble); chk(rst_servo_marble); chk(marble);
        chk(busy); chk(fault); chk(dispense_count);
        rst = 1'b0;
        push("idle_rst_servo", 0); push("idle_busy", 0);
        tick(1);
        chk(rst_servo_marble); chk(busy);

        // Code 3 from 3500
        arm = 1'b1;
        push("ws_busy", 1); push("ws_enable", 0);
        tick(1);
        chk(busy); chk(enable_servo_marble);
        moisture = 12'd3500; moisture_valid = 1'b1;
        push("decide_enable", 0);
        tick(1);
        chk(enable_servo_marble);
        moisture_valid = 1'b0;
        push("c3_enable", 1); push("c3_marble", 3);
        tick(1);
        chk(enable_servo_marble); chk(marble);
        done_servo_marble = 1'b1;
        push("c3_clr_enable", 0); push("c3_clr_rst_servo", 1);
        push("c3_clr_count", 1); push("c3_clr_marble", 0);
        tick(1);
        chk(enable_servo_marble); chk(rst_servo_marble); chk(dispense_count); chk(marble);

        // Code 2 from 2000 (equal to threshold); valid held through cooldown
        done_servo_marble = 1'b0; moisture = 12'd2000; moisture_valid = 1'b1;
        push("cool_rst_servo", 0); push("cool_enable", 0);
        tick(1);
        chk(rst_servo_marble); chk(enable_servo_marble);
        push("cool_exact_early", 0);
        tick(21);
        chk(enable_servo_marble);
        push("cool_exact_on", 1); push("c2_marble", 2);
        tick(1);
        chk(enable_servo_marble); chk(marble);

        // Handshake: done 10 cycles after enable
        moisture_valid = 1'b0;
        push("hs_hold_enable", 1); push("hs_hold_marble", 2);
        tick(10);
        chk(enable_servo_marble); chk(marble);
        done_servo_marble = 1'b1;
        push("hs_clr_enable", 0); push("hs_clr_rst_servo", 1); push("hs_count", 2);
        tick(1);
        chk(enable_servo_marble); chk(rst_servo_marble); chk(dispense_count);
        done_servo_marble = 1'b0;
        push("hs_rst_pulse_end", 0); push("hs_cool_busy", 1);
        tick(1);
        chk(rst_servo_marble); chk(busy);

        // Code 0 from 999: no enable, straight to cooldown
        moisture = 12'd999; moisture_valid = 1'b1;
        push("c0_decide_enable", 0);
        tick(21);
        chk(enable_servo_marble);
        push("c0_enable", 0); push("c0_marble", 0); push("c0_busy", 1);
        tick(1);
        chk(enable_servo_marble); chk(marble); chk(busy);
        moisture = 12'd3500;
        push("c0_cool_ignore_valid", 0);
        tick(21);
        chk(enable_servo_marble);
        push("c0_after_cool_enable", 1); push("c0_after_cool_marble", 3);
        tick(1);
        chk(enable_servo_marble); chk(marble);

        // Timeout
        moisture_valid = 1'b0;
        push("to_pre_enable", 1); push("to_pre_fault", 0);
        tick(49);
        chk(enable_servo_marble); chk(fault);
        push("to_fault", 1); push("to_enable", 0); push("to_rst_servo", 1);
        push("to_busy", 1); push("to_marble", 0);
        tick(1);
        chk(fault); chk(enable_servo_marble); chk(rst_servo_marble); chk(busy); chk(marble);
        push("to_fault_held", 1); push("to_rst_servo_held", 1);
        tick(3);
        chk(fault); chk(rst_servo_marble);
        clear_fault = 1'b1;
        push("cf_fault", 0); push("cf_busy", 0); push("cf_rst_servo", 0); push("cf_count", 2);
        tick(1);
        chk(fault); chk(busy); chk(rst_servo_marble); chk(dispense_count);
        clear_fault = 1'b0;

        // Done and timeout in the same cycle: done wins
        moisture = 12'd3500; moisture_valid = 1'b1;
        push("dt_enable", 1);
        tick(3);
        chk(enable_servo_marble);
        moisture_valid = 1'b0;
        push("dt_pre_enable", 1);
        tick(49);
        chk(enable_servo_marble);
        done_servo_marble = 1'b1;
        push("dt_fault", 0); push("dt_rst_servo", 1); push("dt_count", 3);
        tick(1);
        chk(fault); chk(rst_servo_marble); chk(dispense_count);
        done_servo_marble = 1'b0;

        // Disarm during dispense
        moisture = 12'd2500; moisture_valid = 1'b1;
        push("da_enable", 1); push("da_marble", 2);
        tick(23);
        chk(enable_servo_marble); chk(marble);
        arm = 1'b0; moisture_valid = 1'b0;
        push("da_hold_enable", 1);
        tick(5);
        chk(enable_servo_marble);
        done_servo_marble = 1'b1;
        push("da_clr_enable", 0); push("da_count", 4);
        tick(1);
        chk(enable_servo_marble); chk(dispense_count);
        done_servo_marble = 1'b0;
        push("da_cool_busy", 1);
        tick(20);
        chk(busy);
        push("da_idle_busy", 0);
        tick(1);
        chk(busy);

        // Disarm in WAIT_SAMPLE beats a simultaneous valid
        arm = 1'b1;
        push("wsd_busy", 1);
        tick(1);
        chk(busy);
        arm = 1'b0; moisture_valid = 1'b1;
        push("wsd_idle_busy", 0);
        tick(1);
        chk(busy);
        push("wsd_stay_busy", 0); push("wsd_stay_enable", 0);
        tick(2);
        chk(busy); chk(enable_servo_marble);

        // Reset mid-dispense
        arm = 1'b1; moisture = 12'd3500;
        push("rm_enable", 1);
        tick(3);
        chk(enable_servo_marble);
        rst = 1'b1;
        push("rm_enable_off", 0); push("rm_rst_servo", 1); push("rm_marble", 0);
        push("rm_busy", 0); push("rm_count", 0);
        tick(1);
        chk(enable_servo_marble); chk(rst_servo_marble); chk(marble); chk(busy); chk(dispense_count);
        rst = 1'b0;

        // Saturation: 260 dispenses, done returned one cycle after enable
        for (int i = 0; i < 260; i++) begin
            found = 1'b0;
            for (int c = 0; c < 100; c++) begin
                tick(1);
                if (enable_servo_marble) begin
                    found = 1'b1;
                    break;
                end
            end
            if (!found) begin
                push("sat_wait_enable", 1);
                chk(enable_servo_marble);
                break;
            end
            done_servo_marble = 1'b1;
            tick(1);
            done_servo_marble = 1'b0;
            if (i == 9) begin
                push("sat_count_10", 10);
                chk(dispense_count);
            end
            if (i == 254) begin
                push("sat_count_255", 255);
                chk(dispense_count);
            end
        end
        push("sat_count_final", 255);
        chk(dispense_count);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
